// File: rtl/xg_sdram_arbiter.sv
// xg_sdram_arbiter: shares one SDRAM controller port between video (A, priority) and CPU (B) requesters
module xg_sdram_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int BURST_LEN = 4,
  parameter int MAX_A_RUN = 3
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_wren,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_to_mem,
  output logic              a_ready,
  output logic [1:0]        a_offset,
  input  logic              b_req,
  input  logic              b_wren,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_to_mem,
  output logic              b_ready,
  output logic [1:0]        b_offset,
  output logic [15:0]       from_mem_out,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       to_mem,
  input  logic              mem_ready,
  input  logic [1:0]        mem_offset,
  input  logic [15:0]       from_mem,
  output logic              grant_a,
  output logic              grant_b
);
  localparam int RUN_W = $clog2(MAX_A_RUN + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;
  localparam logic [1:0] LAST  = 2'(BURST_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_A_RUN);
  logic [1:0]        state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       to_mem_q, to_mem_d;
  logic              own_a, own_b, done, pick_a, pick_b;
  // the unused encoding is treated like IDLE so the FSM can never lock up
  always_comb begin
    own_a      = state_q == OWN_A;
    own_b      = state_q == OWN_B;
    done       = mem_ready && mem_offset == LAST;
    pick_b     = b_req && (!a_req || run_q == RUN_MAX);
    pick_a     = a_req && !pick_b;
    state_d    = state_q;
    run_d      = run_q;
    mem_wren_d = mem_wren_q;
    mem_addr_d = mem_addr_q;
    to_mem_d   = to_mem_q;
    if (!own_a && !own_b) begin
      state_d    = pick_b ? OWN_B : pick_a ? OWN_A : IDLE;
      run_d      = (pick_b || !b_req) ? '0 : run_q == RUN_MAX ? run_q : run_q + 1'b1;
      mem_wren_d = pick_b ? b_wren : pick_a ? a_wren : mem_wren_q;
      mem_addr_d = pick_b ? b_addr : pick_a ? a_addr : mem_addr_q;
      to_mem_d   = pick_b ? b_to_mem : pick_a ? a_to_mem : to_mem_q;
    end else begin
      state_d  = done ? IDLE : state_q;
      to_mem_d = own_a ? a_to_mem : b_to_mem;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= IDLE;
      run_q      <= '0;
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      to_mem_q   <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      mem_wren_q <= mem_wren_d;
      mem_addr_q <= mem_addr_d;
      to_mem_q   <= to_mem_d;
    end
  end
  assign grant_a      = own_a;
  assign grant_b      = own_b;
  assign mem_req      = own_a || own_b;
  assign mem_wren     = mem_wren_q;
  assign mem_addr     = mem_addr_q;
  assign to_mem       = to_mem_q;
  assign a_ready      = own_a && mem_ready;
  assign b_ready      = own_b && mem_ready;
  assign a_offset     = own_a ? mem_offset : 2'd0;
  assign b_offset     = own_b ? mem_offset : 2'd0;
  assign from_mem_out = from_mem;
endmodule

// File: tb/tb_xg_sdram_arbiter.sv
// tb_xg_sdram_arbiter: vector table plus directed sequences for grant order, reset and drop cases
module tb_xg_sdram_arbiter;
  logic        clk_sys = 1'b0, rst = 1'b1;
  logic        a_req = 0, a_wren = 0, b_req = 0, b_wren = 0, mem_ready = 0;
  logic [16:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_to_mem = 0, b_to_mem = 0, from_mem = 0;
  logic [1:0]  mem_offset = 0;
  logic        a_ready, b_ready, mem_req, mem_wren, grant_a, grant_b;
  logic [1:0]  a_offset, b_offset;
  logic [16:0] mem_addr;
  logic [15:0] to_mem, from_mem_out;
  int checks = 0, failures = 0;

  always #5 clk_sys = ~clk_sys;

  xg_sdram_arbiter dut (
    .clk_sys(clk_sys), .rst(rst),
    .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_to_mem(a_to_mem),
    .a_ready(a_ready), .a_offset(a_offset),
    .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_to_mem(b_to_mem),
    .b_ready(b_ready), .b_offset(b_offset),
    .from_mem_out(from_mem_out), .mem_req(mem_req), .mem_wren(mem_wren),
    .mem_addr(mem_addr), .to_mem(to_mem), .mem_ready(mem_ready),
    .mem_offset(mem_offset), .from_mem(from_mem),
    .grant_a(grant_a), .grant_b(grant_b)
  );

  typedef struct {
    logic        rst, ar, aw;
    logic [16:0] aa;
    logic [15:0] ad;
    logic        br, bw;
    logic [16:0] ba;
    logic [15:0] bd;
    logic        mr;
    logic [1:0]  mo;
    logic [15:0] fm;
    logic        e_req, e_wren;
    logic [16:0] e_addr;
    logic [15:0] e_tm;
    logic        e_ga, e_gb, e_ardy;
    logic [1:0]  e_aoff;
    logic        e_brdy;
    logic [1:0]  e_boff;
  } vec_t;
  vec_t v[15];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst = 1; a_req = 0; b_req = 0; mem_ready = 0; mem_offset = 0;
    @(negedge clk_sys);
    rst = 0;
  endtask

  task automatic wait_grant(input logic want_a, input string n);
    int k;
    for (k = 1; k <= 8; k++) begin
      @(negedge clk_sys); #2;
      if (mem_req) break;
    end
    chk({n, "_latency"}, 32'(k), 32'd1);
    chk({n, "_grant_a"}, 32'(grant_a), 32'(want_a));
    chk({n, "_grant_b"}, 32'(grant_b), 32'(!want_a));
  endtask

  task automatic burst(input logic is_a, input int drop_b_at, input string n);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      mem_ready = 1; mem_offset = 2'(k);
      if (k == drop_b_at) b_req = 0;
      #2;
      chk($sformatf("%s_b%0d_rdy", n, k), 32'(is_a ? a_ready : b_ready), 32'd1);
      chk($sformatf("%s_b%0d_off", n, k), 32'(is_a ? a_offset : b_offset), 32'(k));
      chk($sformatf("%s_b%0d_other", n, k), 32'(is_a ? b_ready : a_ready), 32'd0);
      chk($sformatf("%s_b%0d_held", n, k), 32'(is_a ? grant_a : grant_b), 32'd1);
    end
  endtask

  task automatic gap(input string n);
    @(negedge clk_sys);
    mem_ready = 0; mem_offset = 0;
    #2;
    chk({n, "_req"}, 32'(mem_req), 32'd0);
    chk({n, "_grants"}, 32'({grant_a, grant_b}), 32'd0);
  endtask

  initial begin
    //        rst ar aw aa        ad       br bw ba        bd      mr mo fm        req wr addr      tm       ga gb ar ao br bo
    v[0]  = '{1, 0, 0, 17'h0,     16'h0,    0, 0, 17'h0,     16'h0,  0, 0, 16'h0,    0, 0, 17'h0,     16'h0,    0, 0, 0, 0, 0, 0};
    v[1]  = '{0, 0, 0, 17'h0,     16'h0,    1, 0, 17'h1ABCD, 16'hBB, 0, 0, 16'h0,    0, 0, 17'h0,     16'h0,    0, 0, 0, 0, 0, 0};
    v[2]  = '{0, 0, 0, 17'h0,     16'h0,    1, 0, 17'h1ABCD, 16'hBB, 0, 0, 16'h0,    1, 0, 17'h1ABCD, 16'hBB,   0, 1, 0, 0, 0, 0};
    v[3]  = '{0, 0, 0, 17'h0,     16'h0,    1, 0, 17'h1ABCD, 16'hBB, 1, 0, 16'h1000, 1, 0, 17'h1ABCD, 16'hBB,   0, 1, 0, 0, 1, 0};
    v[4]  = '{0, 0, 0, 17'h0,     16'h0,    1, 0, 17'h1ABCD, 16'hBB, 1, 1, 16'h1001, 1, 0, 17'h1ABCD, 16'hBB,   0, 1, 0, 0, 1, 1};
    v[5]  = '{0, 0, 0, 17'h0,     16'h0,    1, 0, 17'h1ABCD, 16'hBB, 1, 2, 16'h1002, 1, 0, 17'h1ABCD, 16'hBB,   0, 1, 0, 0, 1, 2};
    v[6]  = '{0, 0, 0, 17'h0,     16'h0,    1, 0, 17'h1ABCD, 16'hBB, 1, 3, 16'h1003, 1, 0, 17'h1ABCD, 16'hBB,   0, 1, 0, 0, 1, 3};
    v[7]  = '{0, 0, 0, 17'h0,     16'h0,    0, 0, 17'h0,     16'h0,  0, 0, 16'h0,    0, 0, 17'h1ABCD, 16'hBB,   0, 0, 0, 0, 0, 0};
    v[8]  = '{0, 1, 1, 17'h00123, 16'h1111, 0, 0, 17'h0,     16'h0,  0, 0, 16'h0,    0, 0, 17'h1ABCD, 16'hBB,   0, 0, 0, 0, 0, 0};
    v[9]  = '{0, 1, 1, 17'h00123, 16'h2222, 0, 0, 17'h0,     16'h0,  1, 0, 16'h0,    1, 1, 17'h00123, 16'h1111, 1, 0, 1, 0, 0, 0};
    v[10] = '{0, 1, 1, 17'h00123, 16'h3333, 0, 0, 17'h0,     16'h0,  1, 1, 16'h0,    1, 1, 17'h00123, 16'h2222, 1, 0, 1, 1, 0, 0};
    v[11] = '{0, 1, 1, 17'h00123, 16'h4444, 0, 0, 17'h0,     16'h0,  1, 2, 16'h0,    1, 1, 17'h00123, 16'h3333, 1, 0, 1, 2, 0, 0};
    v[12] = '{0, 1, 1, 17'h00123, 16'h4444, 0, 0, 17'h0,     16'h0,  1, 3, 16'h0,    1, 1, 17'h00123, 16'h4444, 1, 0, 1, 3, 0, 0};
    v[13] = '{0, 0, 0, 17'h0,     16'h0,    0, 0, 17'h0,     16'h0,  0, 0, 16'h0,    0, 1, 17'h00123, 16'h4444, 0, 0, 0, 0, 0, 0};
    v[14] = '{0, 0, 0, 17'h0,     16'h0,    0, 0, 17'h0,     16'h0,  1, 3, 16'hBEEF, 0, 1, 17'h00123, 16'h4444, 0, 0, 0, 0, 0, 0};
    @(negedge clk_sys);
    @(negedge clk_sys);
    for (int i = 0; i < 15; i++) begin
      string p;
      @(negedge clk_sys);
      rst = v[i].rst; a_req = v[i].ar; a_wren = v[i].aw; a_addr = v[i].aa; a_to_mem = v[i].ad;
      b_req = v[i].br; b_wren = v[i].bw; b_addr = v[i].ba; b_to_mem = v[i].bd;
      mem_ready = v[i].mr; mem_offset = v[i].mo; from_mem = v[i].fm;
      #2;
      p = $sformatf("v%0d", i);
      chk({p, "_mem_req"}, 32'(mem_req), 32'(v[i].e_req));
      chk({p, "_mem_wren"}, 32'(mem_wren), 32'(v[i].e_wren));
      chk({p, "_mem_addr"}, 32'(mem_addr), 32'(v[i].e_addr));
      chk({p, "_to_mem"}, 32'(to_mem), 32'(v[i].e_tm));
      chk({p, "_grant_a"}, 32'(grant_a), 32'(v[i].e_ga));
      chk({p, "_grant_b"}, 32'(grant_b), 32'(v[i].e_gb));
      chk({p, "_a_ready"}, 32'(a_ready), 32'(v[i].e_ardy));
      chk({p, "_a_offset"}, 32'(a_offset), 32'(v[i].e_aoff));
      chk({p, "_b_ready"}, 32'(b_ready), 32'(v[i].e_brdy));
      chk({p, "_b_offset"}, 32'(b_offset), 32'(v[i].e_boff));
      chk({p, "_from_mem"}, 32'(from_mem_out), 32'(v[i].fm));
    end
    // simultaneous requests: A first, then B after one idle cycle
    do_reset();
    a_req = 1; b_req = 1;
    wait_grant(1, "sim_a");
    burst(1, 4, "sim_a");
    a_req = 0;
    gap("sim_gap");
    wait_grant(0, "sim_b");
    burst(0, 4, "sim_b");
    b_req = 0;
    gap("sim_end");
    // starvation guard: A,A,A,B repeating
    do_reset();
    a_req = 1; b_req = 1;
    for (int i = 0; i < 8; i++) begin
      logic want_a;
      want_a = (i % 4) != 3;
      wait_grant(want_a, $sformatf("starve%0d", i));
      burst(want_a, 4, $sformatf("starve%0d", i));
      gap($sformatf("starve%0d_gap", i));
    end
    a_req = 0; b_req = 0;
    // reset in the middle of a B read
    do_reset();
    b_req = 1; b_addr = 17'h0F00F;
    wait_grant(0, "mid_rst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_sys);
      mem_ready = 1; mem_offset = 2'(k);
      #2;
      chk($sformatf("mid_rst_b%0d_rdy", k), 32'(b_ready), 32'd1);
    end
    @(negedge clk_sys);
    mem_ready = 0; mem_offset = 0; rst = 1; b_req = 0;
    @(negedge clk_sys);
    rst = 0;
    #2;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_grant_b", 32'(grant_b), 32'd0);
    a_req = 1; b_req = 1;
    wait_grant(1, "post_rst");
    burst(1, 4, "post_rst");
    a_req = 0; b_req = 0;
    gap("post_rst_gap");
    // B drops its request after beat 0; ownership holds to the last beat
    b_req = 1;
    wait_grant(0, "drop");
    burst(0, 1, "drop");
    gap("drop_gap");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
